mcoi_display_scanner: RTL

MCOI_DISPLAY_SCANNER -- requirements
Module: mcoi_display_scanner

---
 rtl/mcoi_display_scanner.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/mcoi_display_scanner.sv
// Display scanner: snapshots a frame, then shifts each chain out MSB first on
// sclk_o with a latch strobe after every chain; supports queued and automatic refresh.
module mcoi_display_scanner #(
  parameter int NUM_CHAINS     = 8,
  parameter int BITS_PER_CHAIN = 16,
  parameter int CLK_DIV        = 4,
  parameter int LATCH_CYCLES   = 2,
  parameter int AUTO_REFRESH   = 1000000
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 enable_i,
  input  logic                                 update_i,
  input  logic [NUM_CHAINS*BITS_PER_CHAIN-1:0] frame_ib,
  output logic                                 sclk_o,
  output logic                                 data_o,
  output logic                                 latch_o,
  output logic                                 blank_o,
  output logic [2:0]                           csel_ob3,
  output logic                                 busy_o,
  output logic                                 done_o
);

  localparam int FRAME_W  = NUM_CHAINS * BITS_PER_CHAIN;
  localparam int IDX_W    = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int BIT_W    = (BITS_PER_CHAIN > 1) ? $clog2(BITS_PER_CHAIN) : 1;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LAT_W    = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam int REF_W    = (AUTO_REFRESH > 1) ? $clog2(AUTO_REFRESH) : 1;
  localparam int REF_LAST = (AUTO_REFRESH > 0) ? AUTO_REFRESH - 1 : 0;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_e;

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   snap_q, snap_d;
  logic [2:0]           csel_q, csel_d;      // doubles as the chain index
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic [REF_W-1:0]     refresh_q, refresh_d;
  logic                 pending_q, pending_d;
  logic                 shown_q, shown_d;    // set once the first frame has completed
  logic                 sclk_q, sclk_d;
  logic                 data_q, data_d;
  logic                 latch_q, latch_d;
  logic                 blank_q, blank_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 refresh_hit;

  function automatic logic [IDX_W-1:0] bit_index(input logic [2:0] chain,
                                                 input logic [BIT_W-1:0] bitn);
    return IDX_W'(chain) * IDX_W'(BITS_PER_CHAIN) + IDX_W'(bitn);
  endfunction

  // NOTE: every *_d gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    csel_d    = csel_q;
    bit_d     = bit_q;
    div_d     = div_q;
    lat_d     = lat_q;
    refresh_d = refresh_q;
    pending_d = pending_q;
    shown_d   = shown_q;
    sclk_d    = sclk_q;
    data_d    = data_q;
    latch_d   = latch_q;
    blank_d   = blank_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    refresh_hit = (AUTO_REFRESH != 0) && (refresh_q == REF_W'(REF_LAST));

    if (busy_q && update_i) pending_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (enable_i && (AUTO_REFRESH != 0) && !refresh_hit)
          refresh_d = refresh_q + 1'b1;
        if (enable_i && (update_i || pending_q || refresh_hit)) begin
          state_d   = LOAD;
          busy_d    = 1'b1;
          pending_d = 1'b0;
          refresh_d = '0;
        end
      end

      LOAD: begin
        snap_d  = frame_ib;
        state_d = SHIFT;
        csel_d  = 3'd0;
        bit_d   = BIT_W'(BITS_PER_CHAIN - 1);
        div_d   = '0;
        sclk_d  = 1'b0;
        data_d  = frame_ib[BITS_PER_CHAIN-1];
        blank_d = ~shown_q;
      end

      SHIFT: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bit_q == '0) begin
            state_d = LATCH;
            sclk_d  = 1'b0;
            data_d  = 1'b0;
            latch_d = 1'b1;
            blank_d = 1'b1;
            lat_d   = '0;
          end else begin
            bit_d  = bit_q - 1'b1;
            sclk_d = 1'b0;
            data_d = snap_q[bit_index(csel_q, bit_d)];
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      LATCH: begin
        if (lat_q == LAT_W'(LATCH_CYCLES - 1)) begin
          latch_d = 1'b0;
          lat_d   = '0;
          if (csel_q == 3'(NUM_CHAINS - 1)) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            blank_d   = 1'b0;
            shown_d   = 1'b1;
            refresh_d = '0;
          end else begin
            state_d = SHIFT;
            csel_d  = csel_q + 3'd1;
            bit_d   = BIT_W'(BITS_PER_CHAIN - 1);
            div_d   = '0;
            sclk_d  = 1'b0;
            blank_d = ~shown_q;
            data_d  = snap_q[bit_index(csel_d, bit_d)];
          end
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Disable aborts from any state and suppresses the completion pulse.
    if (!enable_i) begin
      state_d   = IDLE;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      pending_d = 1'b0;
      sclk_d    = 1'b0;
      data_d    = 1'b0;
      latch_d   = 1'b0;
      blank_d   = 1'b1;
      div_d     = '0;
      lat_d     = '0;
      refresh_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before this edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      // NOTE: the snapshot is a plain register bank, not a RAM, so clearing it
      // on reset is cheap and keeps a stale frame from leaking out after reset.
      snap_q    <= '0;
      csel_q    <= 3'd0;
      bit_q     <= '0;
      div_q     <= '0;
      lat_q     <= '0;
      refresh_q <= '0;
      pending_q <= 1'b0;
      shown_q   <= 1'b0;
      sclk_q    <= 1'b0;
      data_q    <= 1'b0;
      latch_q   <= 1'b0;
      blank_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      csel_q    <= csel_d;
      bit_q     <= bit_d;
      div_q     <= div_d;
      lat_q     <= lat_d;
      refresh_q <= refresh_d;
      pending_q <= pending_d;
      shown_q   <= shown_d;
      sclk_q    <= sclk_d;
      data_q    <= data_d;
      latch_q   <= latch_d;
      blank_q   <= blank_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sclk_o   = sclk_q;
  assign data_o   = data_q;
  assign latch_o  = latch_q;
  assign blank_o  = blank_q;
  assign csel_ob3 = csel_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule
